param_register_hist: RTL and testbench
======================================

Name: param_register_hist

Overview:
- Parametrised successor to the fixed 4-bit clocked register used in the game logic.
- Holds a WIDTH-bit word under a 3-bit operation mode: hold, load, shift, rotate, increment, clear.
- Keeps a DEPTH-entry history of previous values, so score, lane and step logic can read back earlier states without extra registers.
- Sits between the input-decode logic and the display/score datapath.

Parameters:
- WIDTH, 4: data word width in bits, must be at least 2.
- DEPTH, 4: number of history entries, must be at least 1.
- SELW, 2: width of the history select port, must satisfy 2^SELW >= DEPTH.

Ports:
- C  input  1  clock; all state updates on rising edge.
- Rn  input  1  asynchronous active-low reset.
- I  input  WIDTH  parallel load data.
- M  input  3  operation mode.
- SI  input  1  serial input bit for shift modes.
- SEL  input  SELW  history tap select; 0 = most recent previous value.
- O  output  WIDTH  current register value (registered).
- HO  output  WIDTH  history entry selected by SEL (combinational read of registered storage).
- HV  output  1  high when the SEL entry is valid.
- HCNT  output  SELW+1  number of valid history entries, saturates at DEPTH.
- CHG  output  1  registered pulse: high for one cycle after any edge where O changed value.

Behaviour:
- Reset (Rn low, asynchronous, takes effect immediately regardless of C):
  - O=0, all history entries=0, HCNT=0, CHG=0.
  - HO and HV therefore read 0.
  - Deassertion is not synchronised inside the block; the system reset driver deasserts it away from the clock edge.
- Mode decode, applied on each rising edge of C, next value O':
  - 000 hold: O'=O.
  - 001 load: O'=I.
  - 010 shift left: O'={O[WIDTH-2:0],SI}.
  - 011 shift right: O'={SI,O[WIDTH-1:1]}.
  - 100 rotate left: O'={O[WIDTH-2:0],O[WIDTH-1]}.
  - 101 rotate right: O'={O[0],O[WIDTH-1:1]}.
  - 110 increment: O'=O+1 modulo 2^WIDTH; all-ones wraps to 0, with no carry out.
  - 111 clear: O'=0.
- Latency: one cycle. O reflects the mode/data sampled at edge n immediately after edge n.
- History push:
  - Occurs on any edge where O' != O; unchanged results (including hold, or loading an identical value) do not push.
  - On a push, entry0 <= O (the old value) and entry k <= entry k-1 for k=1..DEPTH-1; the oldest entry is discarded.
  - HCNT increments on each push, saturating at DEPTH.
- CHG is registered as (O' != O) at every edge, so it is a one-cycle pulse coincident with the new O.
- History read:
  - HO = entry[SEL] and HV=1 when SEL < HCNT.
  - When SEL >= HCNT, or SEL >= DEPTH (out of range), HO=0 and HV=0.
- Mode 111 (clear) clears only O. History is retained, and a push occurs if O was non-zero. Only Rn clears history.
- No X propagation: any unused mode encoding cannot exist (all 8 defined).
- SI is ignored in all modes except 010/011.

Optional Feature:
- Macro PARAM_REG_PARITY_EN.
- When defined:
  - Adds output port P (1 bit) = registered even parity (XOR reduction) of the new O, updated on the same edge as O.
  - P resets to 0.
  - Adds input port PCHK (1 bit). When PCHK=1, output PERR (1 bit, registered, sticky until Rn) sets if the XOR reduction of O != P on any edge.
- When undefined: ports P, PCHK and PERR are absent; no parity logic is synthesised; all other behaviour is identical.

Test Plan (WIDTH=4, DEPTH=4, SELW=2 unless noted):
1. Reset mid-operation: load I=5, then drop Rn between edges -> O=0, HCNT=0, CHG=0 immediately, before the next C edge; HV=0 for all SEL.
2. Load sequence: M=001, I=5, then 6, then 10 on successive edges -> O=5,6,10; HCNT=3; SEL=0 gives HO=6, SEL=1 gives HO=5, SEL=2 gives HO=0, SEL=3 gives HV=0.
3. Hold/duplicate suppression: O=10, apply M=000 for 3 edges, then M=001 with I=10 -> O stays 10, CHG stays 0, HCNT unchanged.
4. Shift/rotate: O=4'b1001, M=010 with SI=1 gives O=0011; then M=101 gives O=1001; then M=011 with SI=0 gives O=0100 -> CHG high after each edge, HO(SEL=0) tracks the prior value each time.
5. Increment wrap and history saturation: load 4'hE, then M=110 six times -> O=F,0,1,2,3,4; HCNT saturates at 4; SEL=3 gives HO=0 (the wrapped value); the oldest values E and F have been discarded.
6. Parity (PARAM_REG_PARITY_EN defined):
   - load 4'b0111 -> P=1; load 4'b0101 -> P=0; PERR stays 0 with PCHK=1.
   - Rebuild without the macro -> ports are absent and scenarios 1-5 pass unchanged.

Source files
------------

// File: rtl/param_register_hist.sv
// WIDTH-bit mode-controlled register with a DEPTH-entry change history.
// Optional parity output/checker enabled by defining PARAM_REG_PARITY_EN.
module param_register_hist #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int SELW  = 2
) (
  input  logic             C,
  input  logic             Rn,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       M,
  input  logic             SI,
  input  logic [SELW-1:0]  SEL,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] HO,
  output logic             HV,
  output logic [SELW:0]    HCNT,
  output logic             CHG
`ifdef PARAM_REG_PARITY_EN
  ,
  output logic             P,
  input  logic             PCHK,
  output logic             PERR
`endif
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  localparam logic [SELW:0] HCNT_MAX = (SELW+1)'(DEPTH);

  logic [WIDTH-1:0] next_o;
  logic             changed;
  logic [WIDTH-1:0] hist [DEPTH];

  always_comb begin
    next_o = O;
    case (M)
      MODE_HOLD: next_o = O;
      MODE_LOAD: next_o = I;
      MODE_SHL:  next_o = {O[WIDTH-2:0], SI};
      MODE_SHR:  next_o = {SI, O[WIDTH-1:1]};
      MODE_ROL:  next_o = {O[WIDTH-2:0], O[WIDTH-1]};
      MODE_ROR:  next_o = {O[0], O[WIDTH-1:1]};
      MODE_INC:  next_o = O + 1'b1;
      MODE_CLR:  next_o = '0;
      default:   next_o = O;
    endcase
  end

  assign changed = (next_o != O);

  // Only real value changes push the old word into history.
  always_ff @(posedge C or negedge Rn) begin
    if (!Rn) begin
      O    <= '0;
      CHG  <= 1'b0;
      HCNT <= '0;
      for (int k = 0; k < DEPTH; k++) hist[k] <= '0;
    end else begin
      O   <= next_o;
      CHG <= changed;
      if (changed) begin
        hist[0] <= O;
        for (int k = 1; k < DEPTH; k++) hist[k] <= hist[k-1];
        if (HCNT != HCNT_MAX) HCNT <= HCNT + 1'b1;
      end
    end
  end

  always_comb begin
    HO = '0;
    HV = 1'b0;
    if (({1'b0, SEL} < HCNT) && (int'(SEL) < DEPTH)) begin
      HO = hist[SEL];
      HV = 1'b1;
    end
  end

`ifdef PARAM_REG_PARITY_EN
  // PERR is sticky: once parity disagrees under PCHK it stays set until reset.
  always_ff @(posedge C or negedge Rn) begin
    if (!Rn) begin
      P    <= 1'b0;
      PERR <= 1'b0;
    end else begin
      P <= ^next_o;
      if (PCHK && ((^O) != P)) PERR <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_param_register_hist.sv
// Randomised self-checking bench for param_register_hist against a queue-based model.
// Parity checks are compiled in when PARAM_REG_PARITY_EN is defined.
module tb_param_register_hist;

  logic       C = 1'b0;
  logic       Rn = 1'b0;
  logic [3:0] I = '0;
  logic [2:0] M = '0;
  logic       SI = 1'b0;
  logic [1:0] SEL = '0;
  logic [3:0] O;
  logic [3:0] HO;
  logic       HV;
  logic [2:0] HCNT;
  logic       CHG;
`ifdef PARAM_REG_PARITY_EN
  logic       P;
  logic       PCHK = 1'b1;
  logic       PERR;
`endif

  int n_checks = 0;
  int n_errors = 0;

  int m_o   = 0;
  int m_chg = 0;
  int m_hist[$];

  param_register_hist #(.WIDTH(4), .DEPTH(4), .SELW(2)) dut (
    .C(C), .Rn(Rn), .I(I), .M(M), .SI(SI), .SEL(SEL),
    .O(O), .HO(HO), .HV(HV), .HCNT(HCNT), .CHG(CHG)
`ifdef PARAM_REG_PARITY_EN
    , .P(P), .PCHK(PCHK), .PERR(PERR)
`endif
  );

  always #10 C = ~C;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int parity4(input int v);
    int p = 0;
    for (int b = 0; b < 4; b++) p ^= (v >> b) & 1;
    return p;
  endfunction

  task automatic model_reset();
    m_o = 0;
    m_chg = 0;
    m_hist.delete();
  endtask

  // Arithmetic form of each mode on a 4-bit word.
  task automatic model_edge(input int m, input int i, input int si);
    int nxt;
    case (m)
      0: nxt = m_o;
      1: nxt = i;
      2: nxt = ((m_o * 2) + si) % 16;
      3: nxt = (si * 8) + (m_o / 2);
      4: nxt = ((m_o * 2) % 16) + (m_o / 8);
      5: nxt = ((m_o % 2) * 8) + (m_o / 2);
      6: nxt = (m_o + 1) % 16;
      default: nxt = 0;
    endcase
    m_chg = (nxt != m_o) ? 1 : 0;
    if (m_chg == 1) begin
      m_hist.push_front(m_o);
      if (m_hist.size() > 4) void'(m_hist.pop_back());
    end
    m_o = nxt;
  endtask

  task automatic check_output();
    check("O", int'(O), m_o);
    check("CHG", int'(CHG), m_chg);
    check("HCNT", int'(HCNT), m_hist.size());
`ifdef PARAM_REG_PARITY_EN
    check("P", int'(P), parity4(m_o));
    check("PERR", int'(PERR), 0);
`endif
    for (int s = 0; s < 4; s++) begin
      SEL = 2'(s);
      #1;
      check($sformatf("HV[%0d]", s), int'(HV), (s < m_hist.size()) ? 1 : 0);
      check($sformatf("HO[%0d]", s), int'(HO), (s < m_hist.size()) ? m_hist[s] : 0);
    end
  endtask

  task automatic apply_stimulus(input int m, input int i, input int si);
    M  = 3'(m);
    I  = 4'(i);
    SI = si[0];
    @(posedge C);
    model_edge(m, i, si);
    #1;
    check_output();
  endtask

  // Reset is asserted and released between clock edges.
  task automatic reset_mid_cycle();
    #1 Rn = 1'b0;
    #1;
    model_reset();
    check_output();
    #1 Rn = 1'b1;
  endtask

  initial begin
    model_reset();
    #15 Rn = 1'b1;
    #2;
    check_output();

    apply_stimulus(1, 5, 0);
    check("lit_load5_O", int'(O), 5);
    reset_mid_cycle();
    check("lit_rst_HCNT", int'(HCNT), 0);

    apply_stimulus(1, 5, 0);
    apply_stimulus(1, 6, 0);
    apply_stimulus(1, 10, 0);
    check("lit_seq_O", int'(O), 10);
    check("lit_seq_HCNT", int'(HCNT), 3);
    SEL = 2'd0; #1 check("lit_seq_HO0", int'(HO), 6);
    SEL = 2'd1; #1 check("lit_seq_HO1", int'(HO), 5);
    SEL = 2'd2; #1 check("lit_seq_HO2", int'(HO), 0);
    SEL = 2'd3; #1 check("lit_seq_HV3", int'(HV), 0);

    for (int k = 0; k < 3; k++) apply_stimulus(0, $urandom_range(15), 1);
    apply_stimulus(1, 10, 0);
    check("lit_dup_CHG", int'(CHG), 0);
    check("lit_dup_HCNT", int'(HCNT), 3);

    apply_stimulus(1, 9, 0);
    apply_stimulus(2, 0, 1);
    check("lit_shl_O", int'(O), 3);
    apply_stimulus(5, 0, 1);
    check("lit_ror_O", int'(O), 9);
    apply_stimulus(3, 0, 0);
    check("lit_shr_O", int'(O), 4);
    SEL = 2'd0; #1 check("lit_shr_HO0", int'(HO), 9);

    apply_stimulus(1, 14, 0);
    for (int k = 0; k < 6; k++) apply_stimulus(6, 0, 0);
    check("lit_inc_O", int'(O), 4);
    check("lit_inc_HCNT", int'(HCNT), 4);
    SEL = 2'd3; #1 check("lit_inc_HO3", int'(HO), 0);
    check("lit_inc_HV3", int'(HV), 1);
    SEL = 2'd0; #1 check("lit_inc_HO0", int'(HO), 3);

    apply_stimulus(7, 0, 0);
    check("lit_clr_O", int'(O), 0);
    SEL = 2'd0; #1 check("lit_clr_HO0", int'(HO), 4);

`ifdef PARAM_REG_PARITY_EN
    apply_stimulus(1, 7, 0);
    check("lit_par_0111", int'(P), 1);
    apply_stimulus(1, 5, 0);
    check("lit_par_0101", int'(P), 0);
`endif

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(39) == 0) reset_mid_cycle();
      else apply_stimulus($urandom_range(7), $urandom_range(15), $urandom_range(1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
